// File: rtl/ofdm_demapper.sv
// rtl/ofdm_demapper.sv - QPSK/16-QAM symbol slicer packing hard decisions into bytes behind a small register file
// Optional ERRCNT error statistics enabled by defining OFDM_DEMAP_ERRSTAT_EN.
module ofdm_demapper (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [3:0] address,
   input  logic       data_write,
   input  logic [7:0] data_in,
   output logic [7:0] data_out
);

   localparam logic [3:0] ADDR_CTRL   = 4'h0;
   localparam logic [3:0] ADDR_STATUS = 4'h1;
   localparam logic [3:0] ADDR_SYMBOL = 4'h2;
   localparam logic [3:0] ADDR_RXBYTE = 4'h3;
   localparam logic [3:0] ADDR_ERRCNT = 4'h4;

   typedef enum logic [1:0] {ST_IDLE, ST_SLICE, ST_PACK} state_t;

   state_t     state_q;
   logic       enable_q;
   logic       scheme_q;
   logic       byte_ready_q;
   logic       overrun_q;
   logic       dropped_q;
   logic [2:0] bit_count_q;
   logic [7:0] acc_q;
   logic [7:0] rxbyte_q;
   logic [7:0] sym_q;
   logic [3:0] bits_q;

   logic       wr_ctrl;
   logic       wr_status;
   logic       wr_symbol;
   logic       busy;
   logic [3:0] slice_bits;
   logic [7:0] pack_acc;
   logic [3:0] pack_sum;
   logic [7:0] errcnt_rd;
   logic       unused_ui;

   assign unused_ui = ^ui_in;
   assign wr_ctrl   = data_write && (address == ADDR_CTRL);
   assign wr_status = data_write && (address == ADDR_STATUS);
   assign wr_symbol = data_write && (address == ADDR_SYMBOL);
   assign busy      = (state_q != ST_IDLE);

   // 16-QAM axis decision: Gray-coded so neighbouring levels differ by one bit
   function automatic logic [1:0] qam_axis(input logic [3:0] v);
      case (v)
         4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: qam_axis = 2'b00;
         4'hE, 4'hF:                         qam_axis = 2'b01;
         4'h0, 4'h1:                         qam_axis = 2'b11;
         default:                            qam_axis = 2'b10;
      endcase
   endfunction

   // Hard decision on the latched symbol; QPSK only uses the sign bits
   always_comb begin
      slice_bits = 4'b0000;
      if (scheme_q) begin
         slice_bits = {qam_axis(sym_q[3:0]), qam_axis(sym_q[7:4])};
      end else begin
         slice_bits = {2'b00, sym_q[7], sym_q[3]};
      end
   end

   assign pack_acc = acc_q | ({4'b0000, bits_q} << bit_count_q);
   assign pack_sum = {1'b0, bit_count_q} + (scheme_q ? 4'd4 : 4'd2);

   // Control FSM, accumulator and status flags; later assignments give set priority over W1C
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         enable_q     <= 1'b0;
         scheme_q     <= 1'b0;
         byte_ready_q <= 1'b0;
         overrun_q    <= 1'b0;
         dropped_q    <= 1'b0;
         bit_count_q  <= 3'd0;
         acc_q        <= 8'h00;
         rxbyte_q     <= 8'h00;
         sym_q        <= 8'h00;
         bits_q       <= 4'h0;
      end else begin
         if (wr_status) begin
            if (data_in[0]) byte_ready_q <= 1'b0;
            if (data_in[2]) overrun_q    <= 1'b0;
            if (data_in[3]) dropped_q    <= 1'b0;
         end
         if (wr_ctrl) begin
            enable_q    <= data_in[0];
            scheme_q    <= data_in[1];
            acc_q       <= 8'h00;
            bit_count_q <= 3'd0;
            bits_q      <= 4'h0;
            state_q     <= ST_IDLE;
         end else begin
            if (wr_symbol && enable_q && busy) dropped_q <= 1'b1;
            case (state_q)
               ST_IDLE: begin
                  if (wr_symbol && enable_q) begin
                     sym_q   <= data_in;
                     state_q <= ST_SLICE;
                  end
               end
               ST_SLICE: begin
                  bits_q  <= slice_bits;
                  state_q <= ST_PACK;
               end
               ST_PACK: begin
                  state_q <= ST_IDLE;
                  if (pack_sum[3]) begin
                     acc_q       <= 8'h00;
                     bit_count_q <= 3'd0;
                     if (!byte_ready_q || (wr_status && data_in[0])) begin
                        rxbyte_q     <= pack_acc;
                        byte_ready_q <= 1'b1;
                     end else begin
                        overrun_q <= 1'b1;
                     end
                  end else begin
                     acc_q       <= pack_acc;
                     bit_count_q <= pack_sum[2:0];
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef OFDM_DEMAP_ERRSTAT_EN
   logic [7:0] errcnt_q;
   logic       sym_ideal;

   function automatic logic qpsk_ideal(input logic [3:0] v);
      qpsk_ideal = (v == 4'h1) || (v == 4'hF);
   endfunction

   function automatic logic qam_ideal(input logic [3:0] v);
      qam_ideal = (v == 4'h1) || (v == 4'h3) || (v == 4'hF) || (v == 4'hD);
   endfunction

   // A symbol is ideal only when both axes sit exactly on a constellation point
   always_comb begin
      sym_ideal = 1'b0;
      if (scheme_q) sym_ideal = qam_ideal(sym_q[3:0]) && qam_ideal(sym_q[7:4]);
      else          sym_ideal = qpsk_ideal(sym_q[3:0]) && qpsk_ideal(sym_q[7:4]);
   end

   // Saturating count of off-grid symbols, restarted by any CTRL write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         errcnt_q <= 8'h00;
      end else if (wr_ctrl) begin
         errcnt_q <= 8'h00;
      end else if ((state_q == ST_SLICE) && !sym_ideal && (errcnt_q != 8'hFF)) begin
         errcnt_q <= errcnt_q + 8'd1;
      end
   end

   assign errcnt_rd = errcnt_q;
`else
   assign errcnt_rd = 8'h00;
`endif

   // Combinational register readback; unmapped addresses return zero
   always_comb begin
      data_out = 8'h00;
      case (address)
         ADDR_CTRL:   data_out = {6'b000000, scheme_q, enable_q};
         ADDR_STATUS: data_out = {1'b0, bit_count_q, dropped_q, overrun_q, busy, byte_ready_q};
         ADDR_RXBYTE: data_out = rxbyte_q;
         ADDR_ERRCNT: data_out = errcnt_rd;
         default:     data_out = 8'h00;
      endcase
   end

   assign uo_out = {5'b00000, overrun_q, byte_ready_q, 1'b0};

endmodule

// File: doc/ofdm_demapper.md
OFDM_DEMAPPER -- requirements
Module: tqvp_ofdm_demapper

Interface
REQ-001 SHALL have one clock and reset: reset is asynchronous and active-low.
REQ-002 SHALL provide ports: clk input 1 (clock, 64 MHz nominal); rst_n input 1 (async active-low reset).
REQ-003 SHALL provide ports: ui_in input 8 (unused); uo_out output 8 ([1]=byte_ready, [2]=overrun, others 0).
REQ-004 SHALL provide ports: address input 4; data_write input 1; data_in input 8; data_out output 8 (combinational readback).
REQ-005 SHALL map registers:
- 0x0 CTRL RW: [0] enable, [1] scheme (0=QPSK, 1=16-QAM).
- 0x1 STATUS: [0] byte_ready, [1] busy, [2] overrun, [3] dropped, [6:4] bit_count. Write-1-clears bits 0, 2, 3.
- 0x2 SYMBOL WO: [3:0] I, [7:4] Q, both signed two's complement.
- 0x3 RXBYTE RO: packed byte.
- 0x4 ERRCNT RO: error count (REQ-021).
- Other addresses read 0.

Function
REQ-006 SHALL run FSM IDLE -> SLICE -> PACK -> IDLE; busy=1 in SLICE and PACK.
REQ-007 SHALL accept a symbol on a write to 0x2 with enable=1 in IDLE: latch it and go to SLICE on that edge.
REQ-008 SHALL ignore a symbol write when enable=0, with no flag change.
REQ-009 SHALL, on a symbol write with enable=1 in SLICE/PACK, discard the symbol and set dropped.
REQ-010 SHALL slice QPSK to bit0=I[3], bit1=Q[3] (00:+1+1, 01:-1+1, 11:-1-1, 10:+1-1).
REQ-011 SHALL slice 16-QAM per axis as v<-2 -> 00, -2..-1 -> 01, 0..1 -> 11, v>=2 -> 10; I pair goes to nibble [3:2], Q pair to nibble [1:0].
REQ-012 SHALL, in PACK, insert the sliced bits into an 8-bit accumulator LSB-first at offset bit_count, then add 2 (QPSK) or 4 (16-QAM) to bit_count.
REQ-013 SHALL, when bit_count reaches 8 in PACK:
- if byte_ready=0, load RXBYTE, set byte_ready, and reset bit_count and accumulator to 0;
- if byte_ready=1, discard the new byte, keep RXBYTE, set overrun, and reset bit_count and accumulator to 0.
REQ-014 SHALL give latency of 2 clocks from the accepting edge to the byte_ready rising edge on the completing symbol.
REQ-015 SHALL, when a W1C of byte_ready coincides with a new byte completing, load the new byte and leave byte_ready=1 (set wins).
REQ-016 SHALL, on any write to CTRL, clear accumulator and bit_count, return FSM to IDLE, and discard an in-flight symbol; byte_ready, overrun, dropped and RXBYTE are unaffected.
REQ-017 SHALL hold reading RXBYTE side-effect free; byte_ready clears only by W1C.

Reset
REQ-018 SHALL, on rst_n low, immediately clear CTRL, STATUS, accumulator, RXBYTE, latched symbol and ERRCNT, and set FSM to IDLE.
REQ-019 SHALL drive uo_out=0x00 and data_out at 0x0-0x4 equal to 0x00 during reset.
REQ-020 SHALL, after rst_n deasserts mid-operation, discard any partial byte and accept no symbol until enable is written.

Configuration
REQ-021 SHALL, with OFDM_DEMAP_ERRSTAT_EN defined, increment ERRCNT (8-bit, saturating at 0xFF) in SLICE when either axis is not an ideal point (QPSK: +-1; 16-QAM: +-1/+-3), and clear ERRCNT on a CTRL write.
REQ-022 SHALL, without OFDM_DEMAP_ERRSTAT_EN, include no counter logic and read 0x4 as 0x00.

Verification
REQ-023 SHALL cover: QPSK enable (CTRL=0x01), symbols 0x11, 0x1F, 0xFF, 0xF1 -> RXBYTE=0xB4, byte_ready=1 2 clocks after the 4th write.
REQ-024 SHALL cover: 16-QAM (CTRL=0x03), symbols 0xF3, 0x3D -> RXBYTE=0x29; bit_count reads 4 after the first symbol.
REQ-025 SHALL cover: a second full byte with byte_ready still 1 -> RXBYTE unchanged, overrun=1; W1C 0x04 to 0x1 -> overrun=0.
REQ-026 SHALL cover: symbol write the cycle after an accepted one -> dropped=1, byte still completes from the first symbol only.
REQ-027 SHALL cover: rst_n pulsed low with bit_count=6 -> all registers 0x00, next byte assembles from bit 0.
REQ-028 SHALL cover: with OFDM_DEMAP_ERRSTAT_EN, QPSK symbol 0x22 -> ERRCNT=1, 256 such symbols -> ERRCNT=0xFF; without the macro, 0x4 reads 0x00.
